// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Lets two requesters share the single write port of the 16-bit register
//   bank. Port 0 is the ALU writeback path and port 1 is the memory-load
//   writeback path. Arbitration is round-robin with a req/gnt handshake. The
//   winning address and data are registered and drive the register bank's
//   w_flag/in pair.
//
//   Ports:
//     clk                  rising-edge clock
//     reset                synchronous, active-high reset
//     req0/addr0/data0     port 0 request; held until gnt0 is seen
//     gnt0                 one-cycle pulse when port 0 is accepted
//     req1/addr1/data1     port 1 request; same rules as port 0
//     gnt1                 one-cycle pulse when port 1 is accepted
//     w_flag               register bank write enable
//     w_addr/w_data        register bank write address/data; these hold
//                          their values when no port wins
//     busy                 a request is pending and is not granted on this
//                          edge (combinational)
//
//   Build option:
//     ARB_ZERO_REG_EN      when defined, a grant to address 0 still pulses gnt
//                          and still updates the round-robin pointer, but
//                          w_flag stays low. Register 0 therefore reads as a
//                          hardwired zero.
module reg_write_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt1,
  output logic              w_flag,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic              busy
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

  port_t last;
  logic  eligible0;
  logic  eligible1;
  logic  win0;
  logic  win1;
  logic  wr_en;

  // A port that is in its grant cycle is masked. This stops a request that
  // is still held from being granted twice.
  always_comb begin
    eligible0 = req0 & ~gnt0;
    eligible1 = req1 & ~gnt1;
    win0      = eligible0 & (~eligible1 | (last == PORT1));
    win1      = eligible1 & (~eligible0 | (last == PORT0));
    busy      = (req0 & ~win0) | (req1 & ~win1);
  end

  always_comb begin
    wr_en = 1'b0;
`ifdef ARB_ZERO_REG_EN
    if (win0) begin
      wr_en = (addr0 != '0);
    end else if (win1) begin
      wr_en = (addr1 != '0);
    end
`else
    wr_en = win0 | win1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      w_flag <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
      last   <= PORT1;
    end else begin
      gnt0   <= win0;
      gnt1   <= win1;
      w_flag <= wr_en;
      if (win0) begin
        w_addr <= addr0;
        w_data <= data0;
        last   <= PORT0;
      end else if (win1) begin
        w_addr <= addr1;
        w_data <= data1;
        last   <= PORT1;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] data0, data1;
  logic              gnt0, gnt1, w_flag, busy;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  reg_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
    .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
    .w_flag(w_flag), .w_addr(w_addr), .w_data(w_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              busy;
    logic              gnt0;
    logic              gnt1;
    logic              w_flag;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
  } exp_t;

  exp_t sb[$];

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  // Reference model state: what the bank interface shows after the most
  // recent edge, plus the port that won the previous contest.
  logic              m_gnt0 = 1'b0, m_gnt1 = 1'b0, m_wflag = 1'b0;
  logic [ADDR_W-1:0] m_waddr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  int unsigned       m_last = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus. The expected result of the coming edge is pushed
  // into the scoreboard.
  task automatic cycle(input logic rst,
                       input logic r0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                       input logic r1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    exp_t e;
    logic c0, c1, w0, w1, wr;
    @(negedge clk);
    reset = rst;
    req0 = r0; addr0 = a0; data0 = d0;
    req1 = r1; addr1 = a1; data1 = d1;
    // A request competes unless its port was granted on the previous edge.
    c0 = r0 && !m_gnt0;
    c1 = r1 && !m_gnt1;
    if (c0 && c1) begin
      w0 = (m_last == 1);
      w1 = !w0;
    end else begin
      w0 = c0;
      w1 = c1;
    end
    e.busy = (r0 && !w0) || (r1 && !w1);
    wr = w0 || w1;
`ifdef ARB_ZERO_REG_EN
    if (w0 && a0 == 0) wr = 1'b0;
    if (w1 && a1 == 0) wr = 1'b0;
`endif
    if (rst) begin
      m_gnt0 = 1'b0; m_gnt1 = 1'b0; m_wflag = 1'b0;
      m_waddr = '0; m_wdata = '0; m_last = 1;
    end else begin
      m_gnt0 = w0; m_gnt1 = w1; m_wflag = wr;
      if (w0) begin
        m_waddr = a0; m_wdata = d0; m_last = 0;
      end else if (w1) begin
        m_waddr = a1; m_wdata = d1; m_last = 1;
      end
    end
    e.gnt0 = m_gnt0; e.gnt1 = m_gnt1; e.w_flag = m_wflag;
    e.w_addr = m_waddr; e.w_data = m_wdata;
    sb.push_back(e);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Monitor: busy is checked after the inputs settle. The registered outputs
  // are checked just after the following rising edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("busy", 32'(busy), 32'(e.busy));
        @(posedge clk);
        #1;
        check("gnt0", 32'(gnt0), 32'(e.gnt0));
        check("gnt1", 32'(gnt1), 32'(e.gnt1));
        check("gnt_mutex", 32'(gnt0 & gnt1), 32'd0);
        check("w_flag", 32'(w_flag), 32'(e.w_flag));
        check("w_addr", 32'(w_addr), 32'(e.w_addr));
        check("w_data", 32'(w_data), 32'(e.w_data));
      end
    end
  end

  initial begin : stimulus
    logic              rst, r0, r1;
    logic [ADDR_W-1:0] a0, a1;
    logic [DATA_W-1:0] d0, d1;
    reset = 1'b1;
    req0 = 1'b0; addr0 = '0; data0 = '0;
    req1 = 1'b0; addr1 = '0; data1 = '0;

    // Reset for two cycles.
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    // Single request, then the request is dropped.
    cycle(1'b0, 1'b1, 4'd3, 16'hAA55, 1'b0, '0, '0);
    idle(2);
    // Both ports hold requests continuously after a reset.
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    for (int unsigned i = 0; i < 4; i++)
      cycle(1'b0, 1'b1, 4'd1, 16'hFF00, 1'b1, 4'd2, 16'h00FF);
    idle(1);
    // Port 1 holds a request alone; the grant cycle masks it.
    for (int unsigned i = 0; i < 3; i++)
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 4'd5, 16'h1234);
    idle(1);
    // Reset lands on the grant edge; port 0 must win the next conflict.
    cycle(1'b1, 1'b1, 4'd7, 16'hBEEF, 1'b0, '0, '0);
    cycle(1'b0, 1'b1, 4'd7, 16'hBEEF, 1'b1, 4'd8, 16'hCAFE);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 4'd8, 16'hCAFE);
    idle(1);
    // Write to address 0.
    cycle(1'b0, 1'b1, 4'd0, 16'hFFFF, 1'b0, '0, '0);
    idle(1);

    // Random requesters. A requester holds its request until granted, may
    // abandon it occasionally, and may issue a new request after a grant.
    for (int unsigned i = 0; i < 600; i++) begin
      r0 = req0; a0 = addr0; d0 = data0;
      r1 = req1; a1 = addr1; d1 = data1;
      if (!req0 || m_gnt0) begin
        r0 = ($urandom_range(0, 3) != 0);
        a0 = ADDR_W'($urandom);
        d0 = DATA_W'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        r0 = 1'b0;
      end
      if (!req1 || m_gnt1) begin
        r1 = ($urandom_range(0, 3) != 0);
        a1 = ADDR_W'($urandom);
        d1 = DATA_W'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        r1 = 1'b0;
      end
      rst = ($urandom_range(0, 39) == 0);
      cycle(rst, r0, a0, d0, r1, a1, d1);
    end
    idle(2);

    repeat (3) @(posedge clk);
    #3;
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
